// File: rtl/name_commit_queue.sv
// In-order commit queue: records allocated physical names in program order,
// marks them done on writeback, and frees them from the head one per cycle.
module name_commit_queue #(
    parameter int name_width = 1,
    parameter int depth      = 4,
    parameter int ptr_width  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENQ_E,
    input  logic [name_width-1:0] ENQ_NAME,
    output logic                  ENQ_READY,
    input  logic                  DONE_E,
    input  logic [name_width-1:0] DONE_NAME,
    input  logic                  COMMIT_EN,
    output logic                  FE,
    output logic [name_width-1:0] FREE_NAME,
    output logic [ptr_width:0]    COUNT
);

    localparam logic [ptr_width:0] full_count = (ptr_width + 1)'(depth);

    logic [name_width-1:0] names [depth];
    logic [depth-1:0]      done;
    logic [ptr_width-1:0]  head;
    logic [ptr_width-1:0]  tail;
    logic [ptr_width:0]    count;

    logic                  not_empty;
    logic                  enq_accept;
    logic [depth-1:0]      valid;
    logic [ptr_width-1:0]  offset;

    always_comb begin
        not_empty  = (count != '0);
        ENQ_READY  = (count < full_count);
        enq_accept = ENQ_E && ENQ_READY;
        FE         = not_empty && done[head] && COMMIT_EN;
        FREE_NAME  = not_empty ? names[head] : '0;
        COUNT      = count;
    end

    // An entry is live when its distance from head (mod depth) is below count.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < depth; i++) begin
            offset   = ptr_width'(i) - head;
            valid[i] = ({1'b0, offset} < count);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
            for (int i = 0; i < depth; i++) begin
                names[i] <= '0;
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (DONE_E && valid[i] && (names[i] == DONE_NAME)) begin
                    done[i] <= 1'b1;
                end
            end

            if (FE) begin
                done[head] <= 1'b0;
                head       <= head + ptr_width'(1);
            end

            // The tail slot is never live while enqueue is accepted, so this
            // cannot collide with the done-mark or retire updates above.
            if (enq_accept) begin
                names[tail] <= ENQ_NAME;
                done[tail]  <= DONE_E && (DONE_NAME == ENQ_NAME);
                tail        <= tail + ptr_width'(1);
            end

            case ({enq_accept, FE})
                2'b10:   count <= count + (ptr_width + 1)'(1);
                2'b01:   count <= count - (ptr_width + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_name_commit_queue.sv
// Directed self-checking bench for name_commit_queue (depth 4, 3-bit names).
module tb_name_commit_queue;

    localparam int NW = 3;
    localparam int D  = 4;
    localparam int PW = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENQ_E;
    logic [NW-1:0] ENQ_NAME;
    logic          ENQ_READY;
    logic          DONE_E;
    logic [NW-1:0] DONE_NAME;
    logic          COMMIT_EN;
    logic          FE;
    logic [NW-1:0] FREE_NAME;
    logic [PW:0]   COUNT;

    int checks = 0;
    int errors = 0;

    name_commit_queue #(.name_width(NW), .depth(D), .ptr_width(PW)) dut (
        .CLK(CLK), .RST(RST), .ENQ_E(ENQ_E), .ENQ_NAME(ENQ_NAME),
        .ENQ_READY(ENQ_READY), .DONE_E(DONE_E), .DONE_NAME(DONE_NAME),
        .COMMIT_EN(COMMIT_EN), .FE(FE), .FREE_NAME(FREE_NAME), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ENQ_E = 1'b0; ENQ_NAME = '0; DONE_E = 1'b0; DONE_NAME = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1; COMMIT_EN = 1'b0; idle_inputs();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; COMMIT_EN = 1'b0; idle_inputs();
        tick(); tick();
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d want 0", c, COUNT); end
            checks++; if (ENQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready cyc %0d got %b want 1", c, ENQ_READY); end
            checks++; if (FE !== 1'b0) begin errors++; $display("FAIL reset_fe cyc %0d got %b want 0", c, FE); end
            checks++; if (FREE_NAME !== 3'd0) begin errors++; $display("FAIL reset_free_name cyc %0d got %0d want 0", c, FREE_NAME); end
            tick();
        end
    endtask

    task automatic test_in_order();
        logic [NW-1:0] exp_names [3];
        exp_names = '{3'd4, 3'd5, 3'd6};
        COMMIT_EN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ENQ_E = 1'b1; ENQ_NAME = exp_names[k];
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (COUNT !== 3'd3) begin errors++; $display("FAIL order_count_filled got %0d want 3", COUNT); end
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL order_fe_none_done got %b want 0", FE); end
        DONE_E = 1'b1; DONE_NAME = 3'd5; #1;
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL order_fe_done5 got %b want 0", FE); end
        tick();
        DONE_NAME = 3'd6; #1;
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL order_fe_done6 got %b want 0", FE); end
        tick();
        DONE_NAME = 3'd4; #1;
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL order_fe_same_cycle_done4 got %b want 0", FE); end
        tick();
        idle_inputs(); #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (FE !== 1'b1) begin errors++; $display("FAIL order_fe retire %0d got %b want 1", k, FE); end
            checks++; if (FREE_NAME !== exp_names[k]) begin errors++; $display("FAIL order_free_name retire %0d got %0d want %0d", k, FREE_NAME, exp_names[k]); end
            checks++; if (COUNT !== 3'(3 - k)) begin errors++; $display("FAIL order_count retire %0d got %0d want %0d", k, COUNT, 3 - k); end
            tick();
        end
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL order_count_drained got %0d want 0", COUNT); end
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL order_fe_drained got %b want 0", FE); end
        COMMIT_EN = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [NW-1:0] exp_names [4];
        exp_names = '{3'd2, 3'd3, 3'd4, 3'd7};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ENQ_E = 1'b1; ENQ_NAME = NW'(k + 1);
            tick();
        end
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", COUNT); end
        checks++; if (ENQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ENQ_READY); end
        ENQ_E = 1'b1; ENQ_NAME = 3'd7;
        tick();
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL full_drop_count got %0d want 4", COUNT); end
        DONE_E = 1'b1; DONE_NAME = 3'd1;
        tick();
        idle_inputs(); COMMIT_EN = 1'b1; #1;
        checks++; if (FE !== 1'b1) begin errors++; $display("FAIL full_retire_fe got %b want 1", FE); end
        checks++; if (FREE_NAME !== 3'd1) begin errors++; $display("FAIL full_retire_name got %0d want 1", FREE_NAME); end
        checks++; if (ENQ_READY !== 1'b0) begin errors++; $display("FAIL full_no_bypass_ready got %b want 0", ENQ_READY); end
        tick();
        COMMIT_EN = 1'b0; #1;
        checks++; if (COUNT !== 3'd3) begin errors++; $display("FAIL full_after_retire_count got %0d want 3", COUNT); end
        checks++; if (ENQ_READY !== 1'b1) begin errors++; $display("FAIL full_after_retire_ready got %b want 1", ENQ_READY); end
        ENQ_E = 1'b1; ENQ_NAME = 3'd7;
        tick();
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL wrap_enq_count got %0d want 4", COUNT); end
        for (int k = 0; k < 4; k++) begin
            DONE_E = 1'b1; DONE_NAME = exp_names[k];
            tick();
        end
        idle_inputs(); COMMIT_EN = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (FE !== 1'b1) begin errors++; $display("FAIL wrap_fe retire %0d got %b want 1", k, FE); end
            checks++; if (FREE_NAME !== exp_names[k]) begin errors++; $display("FAIL wrap_free_name retire %0d got %0d want %0d", k, FREE_NAME, exp_names[k]); end
            tick();
        end
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL wrap_drained_count got %0d want 0", COUNT); end
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL wrap_drained_fe got %b want 0", FE); end
        COMMIT_EN = 1'b0;
    endtask

    task automatic test_same_cycle_done();
        do_reset();
        COMMIT_EN = 1'b1;
        ENQ_E = 1'b1; ENQ_NAME = 3'd2; DONE_E = 1'b1; DONE_NAME = 3'd2; #1;
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL same_fe_empty got %b want 0", FE); end
        tick();
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL same_count got %0d want 1", COUNT); end
        checks++; if (FE !== 1'b1) begin errors++; $display("FAIL same_fe got %b want 1", FE); end
        checks++; if (FREE_NAME !== 3'd2) begin errors++; $display("FAIL same_free_name got %0d want 2", FREE_NAME); end
        tick();
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL same_drained_count got %0d want 0", COUNT); end
        COMMIT_EN = 1'b0;
    endtask

    task automatic test_no_match();
        do_reset();
        COMMIT_EN = 1'b1;
        ENQ_E = 1'b1; ENQ_NAME = 3'd1;
        tick();
        idle_inputs();
        DONE_E = 1'b1; DONE_NAME = 3'd3;
        tick();
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL nomatch_count got %0d want 1", COUNT); end
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL nomatch_fe got %b want 0", FE); end
        checks++; if (FREE_NAME !== 3'd1) begin errors++; $display("FAIL nomatch_free_name got %0d want 1", FREE_NAME); end
        tick();
        checks++; if (FE !== 1'b0) begin errors++; $display("FAIL nomatch_fe_later got %b want 0", FE); end
        COMMIT_EN = 1'b0;
    endtask

    task automatic test_commit_hold();
        do_reset();
        ENQ_E = 1'b1; ENQ_NAME = 3'd5; DONE_E = 1'b1; DONE_NAME = 3'd5;
        tick();
        idle_inputs(); #1;
        for (int c = 0; c < 2; c++) begin
            checks++; if (FE !== 1'b0) begin errors++; $display("FAIL hold_fe cyc %0d got %b want 0", c, FE); end
            checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL hold_count cyc %0d got %0d want 1", c, COUNT); end
            checks++; if (FREE_NAME !== 3'd5) begin errors++; $display("FAIL hold_free_name cyc %0d got %0d want 5", c, FREE_NAME); end
            tick();
        end
        COMMIT_EN = 1'b1; #1;
        checks++; if (FE !== 1'b1) begin errors++; $display("FAIL hold_release_fe got %b want 1", FE); end
        tick();
        COMMIT_EN = 1'b0;
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL hold_release_count got %0d want 0", COUNT); end
    endtask

    task automatic test_reset_mid();
        int fe_seen;
        do_reset();
        ENQ_E = 1'b1; ENQ_NAME = 3'd6; DONE_E = 1'b1; DONE_NAME = 3'd6;
        tick();
        ENQ_NAME = 3'd7; DONE_NAME = 3'd7;
        tick();
        idle_inputs(); #1;
        checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL midrst_pre_count got %0d want 2", COUNT); end
        RST = 1'b1;
        tick();
        RST = 1'b0; COMMIT_EN = 1'b1; #1;
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", COUNT); end
        checks++; if (FREE_NAME !== 3'd0) begin errors++; $display("FAIL midrst_free_name got %0d want 0", FREE_NAME); end
        fe_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (FE === 1'b1) fe_seen++;
            tick();
        end
        checks++; if (fe_seen !== 0) begin errors++; $display("FAIL midrst_fe got %0d frees want 0", fe_seen); end
        COMMIT_EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_same_cycle_done();
        test_no_match();
        test_commit_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
